// File: rtl/ws2812_tx.sv
// WS2812 serial transmitter: captures a frame of GRB pixels, sends each bit as a
// fixed-period pulse-width coded symbol, then holds the line low for the latch gap.
module ws2812_tx #(
  parameter int NUM_LEDS = 16,
  parameter int T0H      = 4,
  parameter int T1H      = 8,
  parameter int TBIT     = 15,
  parameter int TRESET   = 600
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [24*NUM_LEDS-1:0]   framebuf,
  input  logic                     start,
  output logic                     dout,
  output logic                     busy,
  output logic                     done
);
  localparam int NB = 24 * NUM_LEDS;
  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = (TRESET > 1) ? $clog2(TRESET) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] TH0      = CW'(T0H);
  localparam logic [CW-1:0] TH1      = CW'(T1H);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(TRESET - 1);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            dout_q, dout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NB-1:0]   frame_rev;

  // Pixel 0 is moved to the top so a plain MSB-first shift yields the wire order.
  always_comb begin
    frame_rev = '0;
    for (int n = 0; n < NUM_LEDS; n++)
      frame_rev[24*(NUM_LEDS-1-n) +: 24] = framebuf[24*n +: 24];
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    lat_d    = lat_q;
    dout_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = SEND;
          shadow_d = frame_rev;
          cyc_d    = '0;
          bit_d    = '0;
          dout_d   = 1'b1;
          busy_d   = 1'b1;
        end
      end
      SEND: begin
        busy_d = 1'b1;
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
            lat_d   = '0;
          end else begin
            bit_d    = bit_q + 1'b1;
            shadow_d = shadow_q << 1;
            dout_d   = 1'b1;
          end
        end else begin
          cyc_d  = cyc_q + 1'b1;
          // Output level for the following cycle of the current symbol.
          dout_d = (cyc_q + 1'b1) < (shadow_q[NB-1] ? TH1 : TH0);
        end
      end
      LATCH: begin
        busy_d = 1'b1;
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cyc_q    <= '0;
      bit_q    <= '0;
      lat_q    <= '0;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      lat_q    <= lat_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Scoreboard bench for ws2812_tx: expected frames are queued at start and the
// line monitor decodes dout symbol by symbol against them.
module tb_ws2812_tx;
  localparam int NUM_LEDS  = 16;
  localparam int T0H       = 4;
  localparam int T1H       = 8;
  localparam int TBIT      = 15;
  localparam int TRESET    = 600;
  localparam int NB        = 24 * NUM_LEDS;
  localparam int FRAME_CYC = NB * TBIT + TRESET;

  typedef struct {
    logic [NB-1:0] bits;
    bit            b2b;
  } exp_t;

  logic          clk, rst, start, dout, busy, done;
  logic [NB-1:0] framebuf;
  logic [23:0]   s_fb;
  logic          s_start, s_dout, s_busy, s_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ndone   = 0;
  exp_t exp_q[$];
  logic s_q[$];

  ws2812_tx #(.NUM_LEDS(NUM_LEDS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) u_dut (
    .clk(clk), .rst(rst), .framebuf(framebuf), .start(start),
    .dout(dout), .busy(busy), .done(done)
  );

  ws2812_tx #(.NUM_LEDS(1), .T0H(1), .T1H(2), .TBIT(3), .TRESET(5)) u_small (
    .clk(clk), .rst(rst), .framebuf(s_fb), .start(s_start),
    .dout(s_dout), .busy(s_busy), .done(s_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] tx_order(input logic [NB-1:0] fb);
    logic [NB-1:0] r;
    for (int b = 0; b < NB; b++) r[b] = fb[24*(b/24) + 23 - (b%24)];
    return r;
  endfunction

  function automatic logic [NB-1:0] rand_frame();
    logic [NB-1:0] r;
    for (int i = 0; i < NB/32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  always @(negedge clk) if (done === 1'b1) ndone <= ndone + 1;

  task automatic send_frame(input logic [NB-1:0] fb, input bit push);
    exp_t e;
    @(negedge clk);
    framebuf = fb;
    start    = 1'b1;
    if (push) begin
      e.bits = tx_order(fb);
      e.b2b  = 1'b0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cnt;
    cnt = 0;
    while (ndone < target && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_wait", ndone, target);
  endtask

  // Line monitor: decodes one queued frame per pass, from first high cycle to done.
  initial begin : mon
    exp_t e;
    int   n, hi, lead, lhi, nbusy, dseen;
    bit   run;
    @(negedge clk);
    forever begin
      while (exp_q.size() == 0) @(negedge clk);
      e = exp_q.pop_front();
      n = 0;
      while (dout !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        chk("frame_start", dout, 1);
        continue;
      end
      if (e.b2b) chk("b2b_gap", n, 1);
      hi = 0; lead = 0; run = 1'b1; lhi = 0; nbusy = 0; dseen = 0;
      for (int k = 0; k <= FRAME_CYC; k++) begin
        if (k > 0) @(negedge clk);
        if (k < NB*TBIT) begin
          if (k % TBIT == 0) begin
            hi = 0; lead = 0; run = 1'b1;
          end
          if (dout) hi++;
          if (dout && run) lead++;
          else run = 1'b0;
          if (k % TBIT == TBIT-1) begin
            chk("bit_hi", hi, e.bits[k/TBIT] ? T1H : T0H);
            chk("bit_shape", lead, hi);
          end
        end else if (k < FRAME_CYC) begin
          if (dout) lhi++;
        end
        if (k < FRAME_CYC) begin
          if (!busy) nbusy++;
          if (done) dseen++;
        end
      end
      chk("latch_hi", lhi, 0);
      chk("busy_drop", nbusy, 0);
      chk("early_done", dseen, 0);
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("dout_end", dout, 0);
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : drv
    logic [NB-1:0] fb;
    exp_t          e;
    rst = 1'b1; start = 1'b0; framebuf = '0;
    s_fb = 24'h0; s_start = 1'b0;
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // single lit green pixel
    fb = '0;
    fb[23:0] = 24'hFF0000;
    send_frame(fb, 1'b1);
    wait_done(1);

    // capture all-zero, then flip input to all-ones while in flight
    send_frame('0, 1'b1);
    framebuf = '1;
    wait_done(2);

    send_frame(rand_frame(), 1'b1);
    wait_done(3);

    // start held high: three consecutive frames, then released mid-frame
    fb = rand_frame();
    @(negedge clk);
    framebuf = fb;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.bits = tx_order(fb);
      e.b2b  = (i > 0);
      exp_q.push_back(e);
    end
    wait_done(5);
    start = 1'b0;
    wait_done(6);
    repeat (20) @(negedge clk);
    chk("no_extra_busy", busy, 0);
    chk("no_extra_done", ndone, 6);

    // abort in the high phase of bit 100
    send_frame(rand_frame(), 1'b0);
    repeat (1500) @(negedge clk);
    chk("pre_rst_dout", dout, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_dout", dout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    chk("abort_nodone", ndone, 6);
    rst = 1'b0;
    send_frame(rand_frame(), 1'b1);
    wait_done(7);
    repeat (10) @(negedge clk);
    chk("final_done_cnt", ndone, 7);

    // minimal timing configuration, checked cycle by cycle
    @(negedge clk);
    s_fb    = 24'hAAAAAA;
    s_start = 1'b1;
    for (int k = 0; k < 77; k++)
      s_q.push_back(k < 72 ? ((k % 3) < (s_fb[23 - k/3] ? 2 : 1)) : 1'b0);
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k < 77; k++) begin
      chk("s_dout", s_dout, s_q.pop_front());
      if (k < 77) chk("s_nodone", s_done, 0);
      @(negedge clk);
    end
    chk("s_done", s_done, 1);
    chk("s_busy", s_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_tx.md
WS2812_TX -- requirements
Module: ws2812_tx

Interface
REQ-001 Parameter NUM_LEDS, default 16: pixels per frame; frame width is 24*NUM_LEDS bits.
REQ-002 Parameter T0H, default 4: clk cycles dout is high for a 0 bit.
REQ-003 Parameter T1H, default 8: clk cycles dout is high for a 1 bit.
REQ-004 Parameter TBIT, default 15: clk cycles per bit period; legal only when 0 < T0H < T1H < TBIT.
REQ-005 Parameter TRESET, default 600: clk cycles dout is held low after the last bit (latch gap).
REQ-006 clk  input  1  single clock; all state on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 framebuf  input  24*NUM_LEDS  frame to send; pixel n at bits [24n+23:24n], sub-pixel order G,R,B from MSB.
REQ-009 start  input  1  request to send one frame; sampled only in IDLE.
REQ-010 dout  output  1  serial line to LED chain data-in.
REQ-011 busy  output  1  high while a frame or its latch gap is in progress.
REQ-012 done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 The state machine SHALL have three states: IDLE, SEND, LATCH.
REQ-014 In IDLE with start=1 at a rising edge, the block SHALL copy framebuf into an internal shadow register, enter SEND, and begin bit 0 at that edge.
REQ-015 After capture, framebuf changes SHALL NOT affect the frame in flight.
REQ-016 Transmit order SHALL be pixel 0 first, then pixel 1, up to pixel NUM_LEDS-1; within a pixel, bit 24n+23 first, bit 24n last.
REQ-017 Each bit SHALL occupy exactly TBIT cycles: dout=1 for the first T0H (bit=0) or T1H (bit=1) cycles, then dout=0 for the rest.
REQ-018 Bits SHALL follow each other with no gap; the first cycle of bit k+1 follows the last cycle of bit k.
REQ-019 After the last cycle of bit 24*NUM_LEDS-1, the block SHALL enter LATCH and hold dout=0 for exactly TRESET cycles.
REQ-020 On leaving LATCH, the block SHALL enter IDLE and assert done for exactly that first IDLE cycle.
REQ-021 Total latency, from the start-sampling edge to the edge asserting done, SHALL be 24*NUM_LEDS*TBIT + TRESET cycles: 6360 with defaults.
REQ-022 busy SHALL be 1 in SEND and LATCH and 0 in IDLE, so busy falls on the same edge done rises.
REQ-023 start SHALL be ignored in SEND and LATCH, with no queuing.
REQ-024 start=1 in the done cycle SHALL be accepted and begin a new frame at that edge (back-to-back frames).
REQ-025 dout SHALL be 0 in IDLE and LATCH.
REQ-026 Cycle and bit counters SHALL be sized for TBIT-1, TRESET-1 and 24*NUM_LEDS-1 and SHALL never wrap within a frame.
REQ-027 dout, busy and done SHALL be registered outputs with no combinational path from start or framebuf.

Reset
REQ-028 rst=1 SHALL immediately, independent of clk, force IDLE, dout=0, busy=0, done=0, and clear all counters and the shadow register.
REQ-029 rst asserted mid-SEND or mid-LATCH SHALL abort the frame without a done pulse; the next frame starts only on a fresh start after rst deasserts.
REQ-030 After rst deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-031 Defaults, framebuf = pixel 0 = 0xFF0000, all others 0, one start pulse -> first 8 bits have 8-cycle highs, remaining 376 bits have 4-cycle highs, each period is 15 cycles, then 600 low cycles, then done for 1 cycle at cycle 6360.
REQ-032 framebuf toggled to all-ones on the cycle after start -> transmitted frame still matches the captured value, every bit a 0-pattern when all-zero was captured.
REQ-033 start held high continuously -> frames run back-to-back with period 6360 cycles, one done per frame, and no extra frame started mid-transfer.
REQ-034 rst pulsed asynchronously (between clk edges) during bit 100 -> dout, busy and done go 0 immediately, no done follows, and the next start produces a full, correct frame.
REQ-035 NUM_LEDS=1, T0H=1, T1H=2, TBIT=3, TRESET=5, framebuf=0xAAAAAA -> bit highs alternate 2,1,2,1,... and done arrives at cycle 77.
